uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single SoC UART transmitter between NUM_REQ byte-stream sources
//  (CPU MMIO TX, BIOS logger, debug trace, ...). Grants are round-robin and
//  packet-locked, so a message ending with 'last' is never interleaved with
//  another source's bytes. Sits between the requesters and the uart_tx serializer.
// PARAMETERS
//  NUM_REQ       4     number of requesters, 2..8
//  LOCK_TIMEOUT  1024  idle cycles before a locked owner's grant is revoked; 0 = never
// PORTS
//  clk          in   1          system clock
//  reset        in   1          synchronous, active-high reset
//  req_valid    in   NUM_REQ    per-requester byte valid
//  req_data     in   8*NUM_REQ  per-requester byte, requester i at [8i+7:8i]
//  req_last     in   NUM_REQ    byte is the final byte of a message
//  req_ready    out  NUM_REQ    byte accepted when req_valid[i] && req_ready[i]
//  tx_valid     out  1          byte available to the UART transmitter
//  tx_data      out  8          byte to transmit
//  tx_ready     in   1          UART transmitter accepts tx_data this cycle
//  grant        out  NUM_REQ    one-hot current owner, all-zero when idle
//  busy         out  1          state != IDLE or tx_valid
// BEHAVIOUR
//  Reset: state=IDLE, grant=0, tx_valid=0, tx_data=0, rr_ptr=0, idle_cnt=0.
//   All req_ready=0. Reset mid-message drops the held byte and the lock.
//  FSM IDLE: if any req_valid, grant the first set bit searching from rr_ptr
//   upward with wrap-around (round-robin). Load grant, go to LOCKED. No byte
//   moves in the arbitration cycle, so first-byte latency is 1 cycle
//   req_valid -> grant, then 1 cycle to tx_valid.
//  FSM LOCKED: req_ready[owner] = !tx_valid || tx_ready. All other req_ready=0.
//   On an owner beat: tx_data<=byte, tx_valid<=1, idle_cnt<=0.
//   On a beat with req_last=1: grant<=0, rr_ptr<=owner+1 (mod NUM_REQ), go to IDLE.
//   No beat and req_valid[owner]=0: idle_cnt++. When idle_cnt==LOCK_TIMEOUT-1
//   (LOCK_TIMEOUT!=0), revoke: grant<=0, rr_ptr<=owner+1, go to IDLE.
//   idle_cnt saturates and never wraps.
//  Output register: single entry. tx_valid clears on tx_valid&&tx_ready
//   unless a new beat loads in the same cycle (back-to-back, 1 byte/cycle max).
//   tx_data holds stable while tx_valid && !tx_ready.
//  IDLE with tx_valid=1: the held byte still drains, and a new grant may be
//   issued in parallel.
//  Simultaneous requests: only one grant per arbitration cycle. Requesters not
//   granted see req_ready=0 and must hold valid/data.
//  NUM_REQ=1 degenerates to pass-through plus lock. rr_ptr width is $clog2(NUM_REQ),
//   minimum 1.
// STRUCTURE
//  uart_arb_pkg: state enum {IDLE, LOCKED}, MAX_REQ=8, and the function
//   onehot_to_idx(). Also shared with the MMIO decoder for the grant readback.
//  Sub-module rr_priority_picker: combinational; inputs req vector and rr_ptr,
//   output one-hot winner. Reused by future bus arbiters.
//  The top level holds the FSM, the idle counter, and the output register.
// TESTING
//  1. Single source: req 0 sends "Hi\n" with last on '\n', tx_ready=1 -> tx_data
//     0x48,0x69,0x0A on consecutive cycles. After grant, grant=0001, then 0000.
//  2. Contention: reqs 0 and 2 both valid with 3-byte messages -> 3 bytes from 0,
//     then 3 bytes from 2. Never interleaved. rr_ptr=3 afterward.
//  3. Fairness: all 4 reqs continuously send 1-byte messages -> grant sequence
//     0,1,2,3,0,... with no requester starved.
//  4. Backpressure: tx_ready low for 5 cycles mid-message -> tx_data stable,
//     req_ready[owner]=0, no byte lost or duplicated.
//  5. Timeout: LOCK_TIMEOUT=8, owner drops valid without last -> grant revoked
//     after 8 idle cycles, and a waiting req 1 is granted next cycle.
//  6. Reset asserted mid-message -> next cycle tx_valid=0, grant=0, req_ready=0,
//     and arbitration restarts at req 0.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART TX arbiter.
// Also used by the MMIO decoder for the grant readback.
package uart_arb_pkg;

    localparam int MAX_REQ = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    function automatic logic [2:0] onehot_to_idx(
        input logic [MAX_REQ-1:0] oh
    );
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = idx | 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first set request at or above ptr,
// wrapping around. Purely combinational, one-hot output.
module rr_priority_picker #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  winner
);

    logic found;
    int   j;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        j      = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                winner[j] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter feeding the single UART
// transmitter from NUM_REQ byte-stream sources.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    input  logic                 tx_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST =
        CW'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);

    arb_state_t        state;
    logic [PW-1:0]     rr_ptr;
    logic [CW-1:0]     idle_cnt;
    logic [NUM_REQ-1:0] pick;
    logic [PW-1:0]     owner_idx;
    logic [PW-1:0]     next_ptr;
    logic [7:0]        owner_data;
    logic              owner_last;
    logic              owner_valid;
    logic              can_load;
    logic              beat;

    rr_priority_picker #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_picker (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .winner (pick)
    );

    assign owner_idx = PW'(onehot_to_idx(MAX_REQ'(grant)));
    assign next_ptr  = (int'(owner_idx) == NUM_REQ - 1) ?
                       '0 : owner_idx + 1'b1;

    always_comb begin
        owner_data  = '0;
        owner_last  = 1'b0;
        owner_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                owner_data  = req_data[8*i +: 8];
                owner_last  = req_last[i];
                owner_valid = req_valid[i];
            end
        end
    end

    // Single-entry output register: refill allowed when empty or draining.
    assign can_load  = !tx_valid || tx_ready;
    assign req_ready = (state == LOCKED) ?
                       (grant & {NUM_REQ{can_load}}) : '0;
    assign beat      = |(req_valid & req_ready);
    assign busy      = (state != IDLE) || tx_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            rr_ptr   <= '0;
            idle_cnt <= '0;
        end else begin
            if (tx_valid && tx_ready) tx_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|req_valid) begin
                        grant    <= pick;
                        idle_cnt <= '0;
                        state    <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (beat) begin
                        tx_data  <= owner_data;
                        tx_valid <= 1'b1;
                        idle_cnt <= '0;
                        if (owner_last) begin
                            grant  <= '0;
                            rr_ptr <= next_ptr;
                            state  <= IDLE;
                        end
                    end else if (!owner_valid) begin
                        if (LOCK_TIMEOUT != 0 && idle_cnt == TO_LAST) begin
                            grant  <= '0;
                            rr_ptr <= next_ptr;
                            state  <= IDLE;
                        end else if (idle_cnt != '1) begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed vector-table bench for uart_tx_arbiter (4 sources,
// short lock timeout) plus hand sequences for multi-cycle cases.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b1;
    logic [3:0]  grant;
    logic        busy;

    int n_total = 0;
    int n_pass  = 0;

    logic [7:0] got[$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ      (4),
        .LOCK_TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .grant     (grant),
        .busy      (busy)
    );

    always @(posedge clk) begin
        if (!reset && tx_valid && tx_ready) got.push_back(tx_data);
    end

    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic [31:0] d;
        logic [3:0]  l;
        logic        tr;
        logic [3:0]  g;
        logic        tv;
        logic [7:0]  td;
        logic [3:0]  rr;
        logic        bz;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rst, input logic [3:0] v, input logic [31:0] d,
        input logic [3:0] l, input logic tr, input logic [3:0] g,
        input logic tv, input logic [7:0] td, input logic [3:0] rr,
        input logic bz
    );
        vec_t r;
        r.rst = rst; r.v = v; r.d = d; r.l = l; r.tr = tr;
        r.g = g; r.tv = tv; r.td = td; r.rr = rr; r.bz = bz;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        req_last = '0;
        tx_ready = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        // single source "Hi\n"
        tbl.push_back(mk(1, 4'h0, 32'h0,  4'h0, 1, 4'h0, 0, 8'h00, 4'h0, 0));
        tbl.push_back(mk(0, 4'h1, 32'h48, 4'h0, 1, 4'h1, 0, 8'h00, 4'h1, 1));
        tbl.push_back(mk(0, 4'h1, 32'h48, 4'h0, 1, 4'h1, 1, 8'h48, 4'h1, 1));
        tbl.push_back(mk(0, 4'h1, 32'h69, 4'h0, 1, 4'h1, 1, 8'h69, 4'h1, 1));
        tbl.push_back(mk(0, 4'h1, 32'h0A, 4'h1, 1, 4'h0, 1, 8'h0A, 4'h0, 1));
        tbl.push_back(mk(0, 4'h0, 32'h0,  4'h0, 1, 4'h0, 0, 8'h0A, 4'h0, 0));
        // contention between 0 and 2
        tbl.push_back(mk(1, 4'h0, 32'h0,  4'h0, 1, 4'h0, 0, 8'h00, 4'h0, 0));
        tbl.push_back(mk(0, 4'h5, 32'h00C000A0, 4'h0, 1, 4'h1, 0, 8'h00, 4'h1, 1));
        tbl.push_back(mk(0, 4'h5, 32'h00C000A0, 4'h0, 1, 4'h1, 1, 8'hA0, 4'h1, 1));
        tbl.push_back(mk(0, 4'h5, 32'h00C000A1, 4'h0, 1, 4'h1, 1, 8'hA1, 4'h1, 1));
        tbl.push_back(mk(0, 4'h5, 32'h00C000A2, 4'h1, 1, 4'h0, 1, 8'hA2, 4'h0, 1));
        tbl.push_back(mk(0, 4'h4, 32'h00C00000, 4'h0, 1, 4'h4, 0, 8'hA2, 4'h4, 1));
        tbl.push_back(mk(0, 4'h4, 32'h00C00000, 4'h0, 1, 4'h4, 1, 8'hC0, 4'h4, 1));
        tbl.push_back(mk(0, 4'h4, 32'h00C10000, 4'h0, 1, 4'h4, 1, 8'hC1, 4'h4, 1));
        tbl.push_back(mk(0, 4'h4, 32'h00C20000, 4'h4, 1, 4'h0, 1, 8'hC2, 4'h0, 1));
        tbl.push_back(mk(0, 4'h0, 32'h0,        4'h0, 1, 4'h0, 0, 8'hC2, 4'h0, 0));
        // all four with 1-byte messages: rr_ptr is 3 here
        tbl.push_back(mk(0, 4'hF, 32'h13121110, 4'hF, 1, 4'h8, 0, 8'hC2, 4'h8, 1));
        tbl.push_back(mk(0, 4'hF, 32'h13121110, 4'hF, 1, 4'h0, 1, 8'h13, 4'h0, 1));
        tbl.push_back(mk(0, 4'hF, 32'h13121110, 4'hF, 1, 4'h1, 0, 8'h13, 4'h1, 1));
        tbl.push_back(mk(0, 4'hF, 32'h13121110, 4'hF, 1, 4'h0, 1, 8'h10, 4'h0, 1));
        tbl.push_back(mk(0, 4'hF, 32'h13121110, 4'hF, 1, 4'h2, 0, 8'h10, 4'h2, 1));
        tbl.push_back(mk(0, 4'hF, 32'h13121110, 4'hF, 1, 4'h0, 1, 8'h11, 4'h0, 1));
        tbl.push_back(mk(0, 4'hF, 32'h13121110, 4'hF, 1, 4'h4, 0, 8'h11, 4'h4, 1));
        tbl.push_back(mk(0, 4'hF, 32'h13121110, 4'hF, 1, 4'h0, 1, 8'h12, 4'h0, 1));
        tbl.push_back(mk(0, 4'hF, 32'h13121110, 4'hF, 1, 4'h8, 0, 8'h12, 4'h8, 1));
        tbl.push_back(mk(0, 4'hF, 32'h13121110, 4'hF, 1, 4'h0, 1, 8'h13, 4'h0, 1));
        tbl.push_back(mk(0, 4'hF, 32'h13121110, 4'hF, 1, 4'h1, 0, 8'h13, 4'h1, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            reset     = tbl[i].rst;
            req_valid = tbl[i].v;
            req_data  = tbl[i].d;
            req_last  = tbl[i].l;
            tx_ready  = tbl[i].tr;
            step();
            chk($sformatf("v%0d_grant", i),     32'(grant),     32'(tbl[i].g));
            chk($sformatf("v%0d_tx_valid", i),  32'(tx_valid),  32'(tbl[i].tv));
            chk($sformatf("v%0d_tx_data", i),   32'(tx_data),   32'(tbl[i].td));
            chk($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(tbl[i].rr));
            chk($sformatf("v%0d_busy", i),      32'(busy),      32'(tbl[i].bz));
        end

        // backpressure mid-message from requester 1
        do_reset();
        got.delete();
        req_valid = 4'h2;
        req_data  = 32'h00003100;
        req_last  = 4'h0;
        step();
        chk("bp_grant", 32'(grant), 32'h2);
        step();
        chk("bp_first", 32'(tx_data), 32'h31);
        req_data = 32'h00003200;
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("bp_hold%0d_data", i), 32'(tx_data), 32'h31);
            chk($sformatf("bp_hold%0d_valid", i), 32'(tx_valid), 32'h1);
            chk($sformatf("bp_hold%0d_ready", i), 32'(req_ready), 32'h0);
        end
        tx_ready = 1'b1;
        step();
        chk("bp_second", 32'(tx_data), 32'h32);
        req_data = 32'h00003300;
        req_last = 4'h2;
        step();
        chk("bp_third", 32'(tx_data), 32'h33);
        chk("bp_release", 32'(grant), 32'h0);
        req_valid = 4'h0;
        req_last  = 4'h0;
        step();
        chk("bp_drained", 32'(tx_valid), 32'h0);
        chk("bp_count", 32'(got.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_byte%0d", i),
                (i < got.size()) ? 32'(got[i]) : 32'hDEAD, 32'(8'h31 + i));
        end

        // lock timeout: owner 0 goes silent, requester 1 waits
        do_reset();
        req_valid = 4'h3;
        req_data  = 32'h00006655;
        req_last  = 4'h2;
        step();
        chk("to_grant0", 32'(grant), 32'h1);
        step();
        chk("to_byte", 32'(tx_data), 32'h55);
        req_valid = 4'h2;
        for (int i = 0; i < 7; i++) begin
            step();
            chk($sformatf("to_held%0d", i), 32'(grant), 32'h1);
        end
        chk("to_waiter_ready", 32'(req_ready[1]), 32'h0);
        step();
        chk("to_revoked", 32'(grant), 32'h0);
        step();
        chk("to_grant1", 32'(grant), 32'h2);
        step();
        chk("to_byte1", 32'(tx_data), 32'h66);
        chk("to_release1", 32'(grant), 32'h0);
        req_valid = 4'h0;
        req_last  = 4'h0;
        step();

        // reset mid-message; rr_ptr is 2 going in
        req_valid = 4'h4;
        req_data  = 32'h00770000;
        tx_ready  = 1'b0;
        step();
        chk("rst_pre_grant", 32'(grant), 32'h4);
        step();
        chk("rst_pre_byte", 32'(tx_data), 32'h77);
        reset = 1'b1;
        step();
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset     = 1'b0;
        req_valid = 4'h5;
        req_data  = 32'h00770088;
        step();
        chk("rst_restart_grant", 32'(grant), 32'h1);
        tx_ready = 1'b1;
        step();
        chk("rst_restart_byte", 32'(tx_data), 32'h88);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
